obm_tx: RTL and testbench

- Output buffer manager: egress counterpart of the ingress buffer manager.
- Accepts 24-bit TSN metadata naming a buffered packet, reads the packet line-by-line from data_cache, and emits it in the 134-bit pkt format toward the port/CPU with a trailing valid flag.
- Returns the buffer ID for release once the tail has been emitted.
- Sits between the egress scheduler (metadata source) and the port TX path.

---
 rtl/obm_tx.sv | 184 ++++++++++++++++++
 tb/tb_obm_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/obm_tx.sv
// Output buffer manager: pops packet metadata, reads the packet line-by-line from
// data_cache, forwards it with a header integrity flag and releases the buffer ID.
module obm_tx #(
    parameter int RD_LAT    = 2,
    parameter int MDQ_DEPTH = 4,
    parameter int LINE_W    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [23:0]  in_obm_md,
    input  logic         in_obm_md_wr,
    output logic         out_obm_md_drop,
    output logic         out_obm_rd_req,
    output logic [15:0]  out_obm_rd_addr,
    input  logic [133:0] in_obm_rd_data,
    input  logic         in_obm_alf,
    output logic [133:0] out_obm_data,
    output logic         out_obm_data_wr,
    output logic         out_obm_valid,
    output logic         out_obm_valid_wr,
    output logic [15:0]  out_obm_flow,
    output logic [7:0]   out_obm_free_ID,
    output logic         out_obm_free_ID_wr
);

    localparam int QAW = $clog2(MDQ_DEPTH);

    typedef enum logic [1:0] {IDLE, RD, DRAIN, REL} state_e;

    state_e              state_q, state_d;
    logic [23:0]         mdq_q [MDQ_DEPTH];
    logic [QAW:0]        wptr_q, rptr_q;
    logic                drop_q;
    logic                q_empty, q_full, q_pop, q_push;
    logic [23:0]         q_head;

    logic [7:0]          id_q;
    logic [LINE_W-1:0]   len_q, idx_q, idx_d;
    logic [15:0]         flow_q;
    logic [7:0]          free_id_q;
    logic                free_wr_q;
    logic                req_last;

    logic [RD_LAT-1:0]   tag_req_q, tag_first_q, tag_last_q;
    logic                exit_v, exit_first, exit_last;
    logic [1:0]          exp_hdr;
    logic                hdr_bad, err_seen, err_q;
    logic [133:0]        data_q;
    logic                data_wr_q, valid_q, valid_wr_q;
    logic                pipe_busy;

    assign q_empty = (wptr_q == rptr_q);
    assign q_full  = (wptr_q[QAW] != rptr_q[QAW]) && (wptr_q[QAW-1:0] == rptr_q[QAW-1:0]);
    assign q_head  = mdq_q[rptr_q[QAW-1:0]];
    assign q_pop   = (state_q == IDLE) && !q_empty;
    // A pop in the same cycle frees the slot, so a write to a full queue still lands.
    assign q_push  = in_obm_md_wr && (!q_full || q_pop);

    always_ff @(posedge clk) begin
        if (q_push) begin
            mdq_q[wptr_q[QAW-1:0]] <= in_obm_md;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            drop_q <= 1'b0;
        end else begin
            if (q_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (q_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            drop_q <= in_obm_md_wr && q_full && !q_pop;
        end
    end

    assign out_obm_rd_req  = (state_q == RD) && !in_obm_alf;
    assign out_obm_rd_addr = {id_q, idx_q};
    assign req_last        = out_obm_rd_req && (idx_q == len_q - 1'b1);

    // Zero-length packets pass through DRAIN so the release lands two cycles after the pop.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (!q_empty) begin
                    idx_d   = '0;
                    state_d = (q_head[15:8] != 8'd0) ? RD : DRAIN;
                end
            end
            RD: begin
                if (out_obm_rd_req) begin
                    idx_d = idx_q + 1'b1;
                    if (req_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!pipe_busy && ((len_q == '0) || valid_wr_q)) begin
                    state_d = REL;
                end
            end
            REL:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            id_q      <= '0;
            len_q     <= '0;
            flow_q    <= '0;
            free_id_q <= '0;
            free_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            if (q_pop) begin
                id_q   <= q_head[7:0];
                len_q  <= LINE_W'(q_head[15:8]);
                flow_q <= {q_head[23:16], q_head[7:0]};
            end
            free_wr_q <= (state_q == DRAIN) && (state_d == REL);
            if ((state_q == DRAIN) && (state_d == REL)) begin
                free_id_q <= id_q;
            end
        end
    end

    assign pipe_busy  = |tag_req_q;
    assign exit_v     = tag_req_q[RD_LAT-1];
    assign exit_first = exit_v && tag_first_q[RD_LAT-1];
    assign exit_last  = exit_v && tag_last_q[RD_LAT-1];
    assign exp_hdr    = exit_last ? 2'b10 : (exit_first ? 2'b01 : 2'b11);
    assign hdr_bad    = exit_v && (in_obm_rd_data[133:132] != exp_hdr);
    assign err_seen   = (exit_first ? 1'b0 : err_q) | hdr_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_req_q   <= '0;
            tag_first_q <= '0;
            tag_last_q  <= '0;
            data_q      <= '0;
            data_wr_q   <= 1'b0;
            valid_q     <= 1'b0;
            valid_wr_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            tag_req_q[0]   <= out_obm_rd_req;
            tag_first_q[0] <= out_obm_rd_req && (idx_q == '0);
            tag_last_q[0]  <= req_last;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_req_q[i]   <= tag_req_q[i-1];
                tag_first_q[i] <= tag_first_q[i-1];
                tag_last_q[i]  <= tag_last_q[i-1];
            end
            data_wr_q  <= exit_v;
            valid_wr_q <= exit_last;
            valid_q    <= exit_last && !err_seen;
            if (exit_v) begin
                data_q <= in_obm_rd_data;
                err_q  <= err_seen;
            end
        end
    end

    assign out_obm_md_drop    = drop_q;
    assign out_obm_data       = data_q;
    assign out_obm_data_wr    = data_wr_q;
    assign out_obm_valid      = valid_q;
    assign out_obm_valid_wr   = valid_wr_q;
    assign out_obm_flow       = flow_q;
    assign out_obm_free_ID    = free_id_q;
    assign out_obm_free_ID_wr = free_wr_q;

endmodule

// File: tb/tb_obm_tx.sv
// Bench for obm_tx: directed timing steps plus randomized packets, with a packet-level
// scoreboard and a data_cache responder that returns lines RD_LAT cycles after a request.
module tb_obm_tx;

    logic         clk;
    logic         rst_n;
    logic [23:0]  in_obm_md;
    logic         in_obm_md_wr;
    logic         out_obm_md_drop;
    logic         out_obm_rd_req;
    logic [15:0]  out_obm_rd_addr;
    logic [133:0] in_obm_rd_data;
    logic         in_obm_alf;
    logic [133:0] out_obm_data;
    logic         out_obm_data_wr;
    logic         out_obm_valid;
    logic         out_obm_valid_wr;
    logic [15:0]  out_obm_flow;
    logic [7:0]   out_obm_free_ID;
    logic         out_obm_free_ID_wr;

    obm_tx #(.RD_LAT(2), .MDQ_DEPTH(4), .LINE_W(8)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_obm_md          (in_obm_md),
        .in_obm_md_wr       (in_obm_md_wr),
        .out_obm_md_drop    (out_obm_md_drop),
        .out_obm_rd_req     (out_obm_rd_req),
        .out_obm_rd_addr    (out_obm_rd_addr),
        .in_obm_rd_data     (in_obm_rd_data),
        .in_obm_alf         (in_obm_alf),
        .out_obm_data       (out_obm_data),
        .out_obm_data_wr    (out_obm_data_wr),
        .out_obm_valid      (out_obm_valid),
        .out_obm_valid_wr   (out_obm_valid_wr),
        .out_obm_flow       (out_obm_flow),
        .out_obm_free_ID    (out_obm_free_ID),
        .out_obm_free_ID_wr (out_obm_free_ID_wr)
    );

    typedef struct {
        logic [7:0] id;
        logic [7:0] flow;
        int         len;
        int         bad;
    } pkt_t;

    pkt_t         expQ[$];
    pkt_t         curPkt;
    int           lenOf[256];
    int           badOf[256];
    int           checkCount = 0;
    int           passCount  = 0;
    int           failCount  = 0;
    int           lineK      = 0;
    logic [133:0] pend0 = '0;
    logic [133:0] pend1 = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packet line as stored in the cache: header by position, payload derived from the address.
    function automatic logic [133:0] lineOf(logic [7:0] id, int k, int len, int bad);
        logic [15:0] a;
        logic [1:0]  h;
        a = {id, 8'(k)};
        if (k == len - 1)  h = 2'b10;
        else if (k == 0)   h = 2'b01;
        else               h = 2'b11;
        if (k == bad)      h = h ^ 2'b10;
        return {h, a[3:0], {8{a}}};
    endfunction

    task automatic checkOutput(input string tag, input logic [133:0] observed, input logic [133:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_rd_req"},  out_obm_rd_req, 0);
        checkOutput({tag, "_rd_addr"}, out_obm_rd_addr, 0);
        checkOutput({tag, "_data_wr"}, out_obm_data_wr, 0);
        checkOutput({tag, "_data"},    out_obm_data, 0);
        checkOutput({tag, "_valid"},   out_obm_valid, 0);
        checkOutput({tag, "_valid_wr"},out_obm_valid_wr, 0);
        checkOutput({tag, "_flow"},    out_obm_flow, 0);
        checkOutput({tag, "_free_id"}, out_obm_free_ID, 0);
        checkOutput({tag, "_free_wr"}, out_obm_free_ID_wr, 0);
        checkOutput({tag, "_drop"},    out_obm_md_drop, 0);
    endtask

    task automatic driveMd(input logic [7:0] flow, input logic [7:0] len, input logic [7:0] id,
                           input int bad, input bit accept);
        in_obm_md    = {flow, len, id};
        in_obm_md_wr = 1'b1;
        lenOf[id]    = int'(len);
        badOf[id]    = bad;
        if (accept) expQ.push_back('{id, flow, int'(len), bad});
    endtask

    // Drives one metadata word in cycle 0 and checks strobe timing cycle by cycle.
    task automatic applyStimulus(input logic [7:0] flow, input logic [7:0] len, input logic [7:0] id,
                                 input int bad, input int ncyc, input logic [31:0] alfMask,
                                 input logic [31:0] reqMask, input logic [31:0] wrMask,
                                 input logic [31:0] vwrMask, input logic [31:0] freeMask);
        int idx = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (c == 0) driveMd(flow, len, id, bad, 1'b1);
            else        in_obm_md_wr = 1'b0;
            in_obm_alf = alfMask[c];
            @(negedge clk);
            checkOutput("rd_req", out_obm_rd_req, reqMask[c]);
            if (reqMask[c]) begin
                checkOutput("rd_addr", out_obm_rd_addr, {id, 8'(idx)});
                idx++;
            end
            checkOutput("data_wr", out_obm_data_wr, wrMask[c]);
            checkOutput("valid_wr", out_obm_valid_wr, vwrMask[c]);
            if (vwrMask[c]) checkOutput("valid", out_obm_valid, bad < 0);
            checkOutput("free_wr", out_obm_free_ID_wr, freeMask[c]);
            if (freeMask[c]) checkOutput("free_id", out_obm_free_ID, id);
            @(posedge clk); #1;
        end
        in_obm_md_wr = 1'b0;
        in_obm_alf   = 1'b0;
    endtask

    // data_cache model: line requested in cycle r is presented during cycle r+2.
    always @(negedge clk) begin
        in_obm_rd_data = pend1;
        pend1 = pend0;
        if (out_obm_rd_req)
            pend0 = lineOf(out_obm_rd_addr[15:8], int'(out_obm_rd_addr[7:0]),
                           lenOf[out_obm_rd_addr[15:8]], badOf[out_obm_rd_addr[15:8]]);
        else
            pend0 = '0;
    end

    // Scoreboard: every emitted line and release is matched against the accepted packets in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            lineK = 0;
        end else begin
            if (out_obm_data_wr) begin
                checkOutput("sb_pending", expQ.size() != 0, 1);
                if (expQ.size() != 0) begin
                    curPkt = expQ[0];
                    checkOutput("line_data", out_obm_data, lineOf(curPkt.id, lineK, curPkt.len, curPkt.bad));
                    checkOutput("flow", out_obm_flow, {curPkt.flow, curPkt.id});
                    checkOutput("tail_valid_wr", out_obm_valid_wr, lineK == curPkt.len - 1);
                    if (lineK == curPkt.len - 1) checkOutput("tail_valid", out_obm_valid, curPkt.bad < 0);
                    lineK++;
                end
            end
            if (out_obm_free_ID_wr) begin
                checkOutput("free_pending", expQ.size() != 0, 1);
                if (expQ.size() != 0) begin
                    curPkt = expQ.pop_front();
                    checkOutput("sb_free_id", out_obm_free_ID, curPkt.id);
                    checkOutput("lines_seen", lineK, curPkt.len);
                    lineK = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int sent;
        logic [7:0] rLen;
        logic [7:0] rFlow;
        int         rBad;

        for (int i = 0; i < 256; i++) begin
            lenOf[i] = 0;
            badOf[i] = -1;
        end
        rst_n        = 1'b0;
        in_obm_md    = '0;
        in_obm_md_wr = 1'b0;
        in_obm_alf   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic three-line packet, then the same with one cycle of backpressure.
        applyStimulus(8'h0A, 8'd3, 8'h07, -1, 10, 32'h0, 32'h1C, 32'hE0, 32'h80, 32'h100);
        applyStimulus(8'h0A, 8'd3, 8'h07, -1, 11, 32'h8, 32'h34, 32'h1A0, 32'h100, 32'h200);
        // Middle line returns a head header: forwarded but flagged invalid.
        applyStimulus(8'h0B, 8'd3, 8'h08, 1, 10, 32'h0, 32'h1C, 32'hE0, 32'h80, 32'h100);
        // Zero-length packet: only a release.
        applyStimulus(8'h0C, 8'd0, 8'h1F, -1, 5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8);

        // Queue overflow while the head packet is blocked by almost-full.
        for (int c = 0; c < 9; c++) begin
            in_obm_alf   = (c < 8);
            in_obm_md_wr = 1'b0;
            if (c == 0)
                driveMd(8'h11, 8'd2, 8'h20, -1, 1'b1);
            else if (c >= 2 && c <= 6)
                driveMd(8'(8'h12 + c), 8'($urandom_range(0, 3)), 8'(8'h1F + c), -1, c != 6);
            @(negedge clk);
            checkOutput("md_drop", out_obm_md_drop, c == 7);
            @(posedge clk); #1;
        end
        in_obm_md_wr = 1'b0;
        n = 0;
        while (expQ.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("fifo_drain", expQ.size(), 0);

        // Reset after the second line of a four-line packet.
        applyStimulus(8'h5C, 8'd4, 8'h33, -1, 7, 32'h0, 32'h3C, 32'h60, 32'h0, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        checkIdleOutputs("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkOutput("post_reset_free_wr", out_obm_free_ID_wr, 0);
            checkOutput("post_reset_data_wr", out_obm_data_wr, 0);
            @(posedge clk); #1;
        end
        applyStimulus(8'h66, 8'd2, 8'h34, -1, 10, 32'h0, 32'h0C, 32'h60, 32'h40, 32'h80);

        // Randomized packets with random backpressure, scoreboard-checked.
        sent = 0;
        n    = 0;
        while ((sent < 8 || expQ.size() != 0) && n < 3000) begin
            in_obm_alf   = ($urandom_range(0, 3) == 0);
            in_obm_md_wr = 1'b0;
            if (sent < 8 && expQ.size() < 3 && $urandom_range(0, 2) == 0) begin
                rLen  = 8'($urandom_range(0, 6));
                rFlow = 8'($urandom);
                rBad  = (rLen != 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(rLen) - 1)) : -1;
                driveMd(rFlow, rLen, 8'(8'h40 + sent), rBad, 1'b1);
                sent++;
            end
            @(posedge clk); #1;
            n++;
        end
        in_obm_md_wr = 1'b0;
        in_obm_alf   = 1'b0;
        checkOutput("random_sent", sent, 8);
        checkOutput("random_drain", expQ.size(), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
